// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//   Data-memory access controller between the rv32i core load/store port and a
//   word-wide data RAM (synchronous read with 1-cycle latency, no byte enables).
//   Handles one request at a time. Sub-word loads are aligned and then sign- or
//   zero-extended. Byte and halfword stores are done as a read-modify-write of
//   the full 32-bit word.
//
//   Build option: DMEM_ALIGN_CHK_EN
//     defined   : misaligned half/word accesses complete at once with rsp_err=1
//                 and never touch the RAM.
//     undefined : rsp_err is always 0. Misaligned addresses are force-aligned
//                 (half drops addr[0], word drops addr[1:0]) and then handled
//                 as normal accesses.
//
// Ports
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   req_valid/ready   request handshake; ready only while idle
//   req_we            1=store, 0=load
//   req_size          0=byte, 1=half, 2/3=word
//   req_unsigned      load zero-extend (1) / sign-extend (0)
//   req_addr          byte address; bits above AW+1 alias
//   req_wdata         right-aligned store data
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         load result (0 for stores and errors)
//   rsp_err           misaligned access flag
//   ram_we/waddr/wdata  RAM write port
//   ram_re/raddr/rdata  RAM read port (rdata valid the cycle after ram_re)
// -----------------------------------------------------------------------------
module dmem_ctrl #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic          ram_we,
   output logic [AW-1:0] ram_waddr,
   output logic [31:0]   ram_wdata,
   output logic          ram_re,
   output logic [AW-1:0] ram_raddr,
   input  logic [31:0]   ram_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RMW  = 2'd2
   } state_t;

   state_t          state_reg;
   logic [AW+1:0]   addr_reg;
   logic [1:0]      size_reg;      // normalised: 0=byte, 1=half, 2=word
   logic            unsigned_reg;
   logic [15:0]     wdata_reg;     // only the low half is needed for RMW
   logic            rsp_valid_reg;
   logic [31:0]     rsp_rdata_reg;
   logic            rsp_err_reg;

   logic            accept;
   logic            size_half;
   logic            size_word;
   logic [1:0]      size_norm;
   logic            misaligned;
   logic [AW+1:0]   addr_in;
   logic            direct_write;
   logic            start_read;
   logic [31:0]     merged;
   logic [15:0]     load_lane;
   logic [31:0]     load_data;
   logic            unused_addr_bits;

   // Address bits above the RAM range alias onto the same words.
   assign unused_addr_bits = ^req_addr[31:AW+2];

   assign req_ready = (state_reg == IDLE);
   assign accept    = req_valid && (state_reg == IDLE);
   assign size_half = (req_size == 2'd1);
   assign size_word = req_size[1];
   assign size_norm = {req_size[1], req_size[0] & ~req_size[1]};

`ifdef DMEM_ALIGN_CHK_EN
   assign misaligned = (size_half && req_addr[0]) ||
                       (size_word && (req_addr[1:0] != 2'b00));
   assign addr_in    = req_addr[AW+1:0];
`else
   assign misaligned = 1'b0;
   always_comb begin
      addr_in = req_addr[AW+1:0];
      if (size_half) addr_in[0]   = 1'b0;
      if (size_word) addr_in[1:0] = 2'b00;
   end
`endif

   // A full-word store goes straight to the RAM in the accept cycle; every
   // other legal access first reads the word.
   assign direct_write = accept && req_we && size_word && !misaligned;
   assign start_read   = accept && !misaligned && (!req_we || !size_word);

   // Gating with rst_n kills a pending RMW write the instant reset asserts.
   assign ram_re    = rst_n && start_read;
   assign ram_raddr = addr_in[AW+1:2];
   assign ram_we    = rst_n && (direct_write || (state_reg == RMW));
   assign ram_waddr = (state_reg == RMW) ? addr_reg[AW+1:2] : addr_in[AW+1:2];
   assign ram_wdata = (state_reg == RMW) ? merged : req_wdata;

   // Byte-lane merge for RMW: replace the addressed lane(s), keep the rest.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic       lane_hit;
         logic [7:0] lane_src;
         assign lane_hit = (size_reg == 2'd0) ? (addr_reg[1:0] == LANE)
                                              : (addr_reg[1] == LANE[1]);
         assign lane_src = ((size_reg == 2'd0) || !LANE[0]) ? wdata_reg[7:0]
                                                             : wdata_reg[15:8];
         assign merged[8*gi +: 8] = lane_hit ? lane_src : ram_rdata[8*gi +: 8];
      end
   endgenerate

   // Latched addresses are always aligned to the access size here, so a
   // byte-granular shift positions both byte and half lanes at bit 0.
   assign load_lane = 16'(ram_rdata >> {addr_reg[1:0], 3'b000});

   always_comb begin
      load_data = ram_rdata;
      case (size_reg)
         2'd0:    load_data = {{24{~unsigned_reg & load_lane[7]}},  load_lane[7:0]};
         2'd1:    load_data = {{16{~unsigned_reg & load_lane[15]}}, load_lane};
         default: load_data = ram_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         size_reg      <= 2'd0;
         unsigned_reg  <= 1'b0;
         wdata_reg     <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= 1'b0;
      end else begin
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  addr_reg     <= addr_in;
                  size_reg     <= size_norm;
                  unsigned_reg <= req_unsigned;
                  wdata_reg    <= req_wdata[15:0];
                  if (misaligned) begin
                     rsp_valid_reg <= 1'b1;
                     rsp_err_reg   <= 1'b1;
                  end else if (direct_write) begin
                     rsp_valid_reg <= 1'b1;
                  end else begin
                     state_reg <= req_we ? RMW : LOAD;
                  end
               end
            end
            LOAD: begin
               rsp_valid_reg <= 1'b1;
               rsp_rdata_reg <= load_data;
               state_reg     <= IDLE;
            end
            RMW: begin
               rsp_valid_reg <= 1'b1;
               state_reg     <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
//   Self-checking bench for dmem_ctrl. A behavioural RAM with registered read
//   sits on the RAM port. Expected results come from a byte-addressed
//   reference memory that applies the load/store rules with plain arithmetic.
//   Follows DMEM_ALIGN_CHK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [1:0]    req_size = 2'd0;
   logic          req_unsigned = 1'b0;
   logic [31:0]   req_addr = '0;
   logic [31:0]   req_wdata = '0;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [31:0]   ram_wdata;
   logic          ram_re;
   logic [AW-1:0] ram_raddr;
   logic [31:0]   ram_rdata;

   logic [31:0]   mem [0:(1<<AW)-1];
   logic          preload = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [31:0]   pl_data = '0;

   logic [7:0]    ref_bytes [0:4*(1<<AW)-1];
   logic [31:0]   last_rdata;
   logic [31:0]   ra;
   logic [31:0]   bb;

   int checks = 0;
   int errors = 0;

   dmem_ctrl #(.AW(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .ram_we       (ram_we),
      .ram_waddr    (ram_waddr),
      .ram_wdata    (ram_wdata),
      .ram_re       (ram_re),
      .ram_raddr    (ram_raddr),
      .ram_rdata    (ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (preload)     mem[pl_addr]   <= pl_data;
      else if (ram_we) mem[ram_waddr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_raddr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Little-endian read from the byte reference, extended per the load rules.
   function automatic logic [31:0] ref_load(input int ea, input int sz, input bit uns);
      longint v;
      if (sz == 0) begin
         v = longint'(ref_bytes[ea]);
         if (!uns && v >= 128) v = v - 256;
      end else if (sz == 1) begin
         v = longint'(ref_bytes[ea]) + 256 * longint'(ref_bytes[ea+1]);
         if (!uns && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(ref_bytes[ea]) + 256 * longint'(ref_bytes[ea+1]) +
             65536 * longint'(ref_bytes[ea+2]) + 16777216 * longint'(ref_bytes[ea+3]);
      end
      return 32'(v);
   endfunction

   // One complete request: drive, check RAM strobes, wait for and check response.
   task automatic do_req(input string name, input bit we, input logic [1:0] size,
                         input bit uns, input logic [31:0] addr, input logic [31:0] wdata);
      int ea, sz, lat;
      bit mis, exp_re, exp_we, exp_err;
      logic [31:0] exp_rd;
      ea  = int'(addr[AW+1:0]);
      sz  = (size == 2'd3) ? 2 : int'(size);
      mis = (sz == 1 && ea % 2 != 0) || (sz == 2 && ea % 4 != 0);
`ifndef DMEM_ALIGN_CHK_EN
      if (mis) begin
         ea  = ea - (ea % ((sz == 1) ? 2 : 4));
         mis = 1'b0;
      end
`endif
      exp_rd = '0; exp_err = mis; exp_re = 1'b0; exp_we = 1'b0; lat = 1;
      if (!mis) begin
         if (we && sz == 2) exp_we = 1'b1;
         else begin
            exp_re = 1'b1;
            lat    = 2;
            if (!we) exp_rd = ref_load(ea, sz, uns);
         end
      end

      @(negedge clk);
      chk1({name, "/quiet"}, rsp_valid, 1'b0);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      #1;
      chk1({name, "/ready"}, req_ready, 1'b1);
      chk1({name, "/ram_re"}, ram_re, exp_re);
      chk1({name, "/ram_we"}, ram_we, exp_we);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      if (lat == 2) begin
         chk1({name, "/busy_rsp"}, rsp_valid, 1'b0);
         chk1({name, "/busy_ready"}, req_ready, 1'b0);
         chk1({name, "/rmw_we"}, ram_we, we);
         chk1({name, "/busy_re"}, ram_re, 1'b0);
         @(posedge clk);
         @(negedge clk);
         #1;
      end
      chk1({name, "/rsp_valid"}, rsp_valid, 1'b1);
      chk({name, "/rsp_rdata"}, rsp_rdata, exp_rd);
      chk1({name, "/rsp_err"}, rsp_err, exp_err);
      chk1({name, "/ready_after"}, req_ready, 1'b1);
      last_rdata = rsp_rdata;
      if (we && !mis)
         for (int i = 0; i < (1 << sz); i++) ref_bytes[ea+i] = wdata[8*i +: 8];
      $display("txn %s we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
               name, we, size, uns, addr, wdata, last_rdata, rsp_err);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      // Fill the low RAM words (and the reference) with random contents.
      for (int w = 0; w < 32; w++) begin
         @(negedge clk);
         preload = 1'b1;
         pl_addr = AW'(w);
         pl_data = $urandom;
         for (int b = 0; b < 4; b++) ref_bytes[4*w+b] = pl_data[8*b +: 8];
      end
      @(negedge clk);
      preload = 1'b0;
      repeat (3) @(negedge clk);
      chk1("in_reset/rsp_valid", rsp_valid, 1'b0);
      chk1("in_reset/ram_we", ram_we, 1'b0);
      rst_n = 1'b1;
      #1;
      chk1("reset/req_ready", req_ready, 1'b1);
      chk1("reset/rsp_valid", rsp_valid, 1'b0);
      chk1("reset/ram_we", ram_we, 1'b0);
      chk1("reset/ram_re", ram_re, 1'b0);
      chk("reset/rsp_rdata", rsp_rdata, 32'h0);
      chk1("reset/rsp_err", rsp_err, 1'b0);

      do_req("st_w_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
      do_req("ld_w_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      chk("spec/ld_w_10", last_rdata, 32'hDEADBEEF);
      do_req("st_b_11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h5A);
      do_req("ld_w_10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      chk("spec/merge", last_rdata, 32'hDEAD5AEF);
      do_req("ld_bs_13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
      chk("spec/ld_bs_13", last_rdata, 32'hFFFFFFDE);
      do_req("ld_bu_13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
      chk("spec/ld_bu_13", last_rdata, 32'h000000DE);
      do_req("ld_hs_12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
      chk("spec/ld_hs_12", last_rdata, 32'hFFFFDEAD);
      do_req("ld_w_12", 1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
`ifdef DMEM_ALIGN_CHK_EN
      chk("spec/ld_w_12_err", last_rdata, 32'h0);
`else
      chk("spec/ld_w_12_forced", last_rdata, 32'hDEAD5AEF);
`endif
      do_req("ld_h_odd", 1'b0, 2'd1, 1'b1, 32'h11, 32'h0);
      do_req("ld_w_alias", 1'b0, 2'd3, 1'b0, 32'hABC00010, 32'h0);
      chk("spec/alias", last_rdata, 32'hDEAD5AEF);

      // Reset during the RMW cycle must drop the write and the response.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h11; req_wdata = 32'hA5;
      #1;
      chk1("rmw_rst/ram_re", ram_re, 1'b1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk1("rmw_rst/ram_we_pending", ram_we, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("rmw_rst/ram_we_killed", ram_we, 1'b0);
      chk1("rmw_rst/rsp_valid", rsp_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk1("rmw_rst/rsp_after", rsp_valid, 1'b0);
      rst_n = 1'b1;
      $display("txn rmw_rst store byte 0xA5 @0x11 aborted by reset");
      do_req("ld_after_rst", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      chk("spec/unchanged", last_rdata, 32'hDEAD5AEF);

      // Word store immediately followed by a load of the same word.
      bb = $urandom;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h40; req_wdata = bb;
      #1;
      chk1("b2b/ram_we", ram_we, 1'b1);
      @(posedge clk);
      @(negedge clk);
      req_we = 1'b0; req_wdata = '0;
      #1;
      chk1("b2b/st_rsp", rsp_valid, 1'b1);
      chk1("b2b/ready", req_ready, 1'b1);
      chk1("b2b/ram_re", ram_re, 1'b1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk1("b2b/ld_busy", rsp_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk1("b2b/ld_rsp", rsp_valid, 1'b1);
      chk("b2b/ld_rdata", rsp_rdata, bb);
      for (int i = 0; i < 4; i++) ref_bytes[64+i] = bb[8*i +: 8];
      $display("txn b2b store+load @0x40 wdata=%h rdata=%h", bb, rsp_rdata);

      // Random mix over a small window with aliased upper address bits.
      for (int n = 0; n < 300; n++) begin
         ra = $urandom & 32'hFFFFF03F;
         do_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ra, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
